// File: rtl/sdram_ctrl_pkg.sv
// Shared definitions for the SDRAM controller front end: arbiter state
// encodings and a one-hot to index helper.
package sdram_ctrl_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_GRANT = 2'd1;
    localparam logic [1:0] ARB_HOLD  = 2'd2;

    localparam int PORT_IDX_W = 3;

    // OR-reduce the indices of set bits; exact for a one-hot or all-zero input.
    function automatic logic [PORT_IDX_W-1:0] onehot_to_idx(input logic [7:0] oh);
        logic [PORT_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | PORT_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Controller-side access bus between the port arbiter (master) and the
// internal SDRAM controller (slave).
interface sdram_port_arbiter_if;
    // Handshake: the master holds acc_o (with adr/dat/sel/we stable) until the
    // slave pulses ack_i for one cycle; ack_i without acc_o has no meaning.
    logic [31:0] adr_o;
    logic [15:0] dat_o;
    logic [1:0]  sel_o;
    logic        acc_o;
    logic        we_o;
    logic        ack_i;
    logic [15:0] dat_i;
    logic [31:0] adr_i;

    modport master (
        output adr_o, dat_o, sel_o, acc_o, we_o,
        input  ack_i, dat_i, adr_i
    );

    modport slave (
        input  adr_o, dat_o, sel_o, acc_o, we_o,
        output ack_i, dat_i, adr_i
    );
endinterface

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after index 'last',
// wrapping modulo N.
module rr_pick
    import sdram_ctrl_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]            req,
    input  logic [PORT_IDX_W-1:0]   last,
    output logic [N-1:0]            pick,
    output logic [PORT_IDX_W-1:0]   pick_idx
);

    logic [3:0] cand;
    logic       found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        // i = N wraps back to 'last' itself, so it is visited with lowest priority.
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, last} + 4'(i);
            if (cand >= 4'(N)) cand = cand - 4'(N);
            for (int j = 0; j < N; j++) begin
                if (!found && cand == 4'(j) && req[j]) begin
                    pick[j] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

    assign pick_idx = onehot_to_idx(8'(pick));

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller access bus between
// wb_port instances; keeps a grant across the short gap inside a refill.
module sdram_port_arbiter
    import sdram_ctrl_pkg::*;
#(
    parameter int WB_PORTS    = 3,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                    sdram_clk,
    input  logic                    sdram_rst,
    input  logic [32*WB_PORTS-1:0]  wbp_adr_i,
    input  logic [16*WB_PORTS-1:0]  wbp_dat_i,
    input  logic [2*WB_PORTS-1:0]   wbp_sel_i,
    input  logic [WB_PORTS-1:0]     wbp_acc_i,
    input  logic [WB_PORTS-1:0]     wbp_we_i,
    output logic [WB_PORTS-1:0]     wbp_ack_o,
    output logic [15:0]             wbp_dat_o,
    output logic [31:0]             wbp_adr_o,
    output logic [WB_PORTS-1:0]     grant_o,
    output logic [1:0]              arb_state,
    sdram_port_arbiter_if.master    bus
);

    logic [1:0]             state;
    logic [WB_PORTS-1:0]    grant;
    logic [PORT_IDX_W-1:0]  last;
    logic [3:0]             hold_cnt;

    logic [WB_PORTS-1:0]    pick;
    logic [PORT_IDX_W-1:0]  pick_idx;
    logic [3:0]             hold_next;
    logic                   hold_release;

    logic                   owner_acc;
    logic                   owner_we;
    logic [31:0]            owner_adr;
    logic [15:0]            owner_dat;
    logic [1:0]             owner_sel;

    rr_pick #(.N(WB_PORTS)) u_pick (
        .req      (wbp_acc_i),
        .last     (last),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // Release happens on the cycle the incremented count reaches HOLD_CYCLES-1.
    assign hold_next    = hold_cnt + 4'd1;
    assign hold_release = hold_next >= 4'(HOLD_CYCLES - 1);

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            last     <= PORT_IDX_W'(WB_PORTS - 1);
            hold_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|wbp_acc_i) begin
                        grant <= pick;
                        last  <= pick_idx;
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!owner_acc) begin
                        hold_cnt <= '0;
                        state    <= ARB_HOLD;
                    end
                end
                ARB_HOLD: begin
                    // Other requesters are deliberately not looked at here.
                    if (owner_acc) begin
                        state <= ARB_GRANT;
                    end else if (hold_release) begin
                        grant <= '0;
                        state <= ARB_IDLE;
                    end else begin
                        hold_cnt <= hold_next;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        owner_acc = 1'b0;
        owner_we  = 1'b0;
        owner_adr = '0;
        owner_dat = '0;
        owner_sel = '0;
        for (int n = 0; n < WB_PORTS; n++) begin
            if (grant[n]) begin
                owner_acc = wbp_acc_i[n];
                owner_we  = wbp_we_i[n];
                owner_adr = wbp_adr_i[32*n +: 32];
                owner_dat = wbp_dat_i[16*n +: 16];
                owner_sel = wbp_sel_i[2*n +: 2];
            end
        end
    end

    assign bus.acc_o = owner_acc && (state != ARB_IDLE);
    assign bus.we_o  = owner_we;
    assign bus.adr_o = owner_adr;
    assign bus.dat_o = owner_dat;
    assign bus.sel_o = owner_sel;

    // Grant is still set during HOLD, so a late ack reaches its owner.
    assign wbp_ack_o = {WB_PORTS{bus.ack_i}} & grant;
    assign wbp_dat_o = bus.dat_i;
    assign wbp_adr_o = bus.adr_i;
    assign grant_o   = grant;
    assign arb_state = state;

endmodule
